oam_dma: RTL
============

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter XFER_LEN, default 256, bytes copied per transfer (power of two, 2..256).
REQ-002 Parameter ADDR_W, default 16, CPU address bus width.
REQ-003 clk  in  1  CPU clock (divided clock produced by cpuClockDivider).
REQ-004 rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 reg_wr  in  1  one-cycle CPU write strobe, already decoded for address 0x4014.
REQ-006 reg_wdata  in  8  source page number written by CPU.
REQ-007 cpu_halt  out  1  stalls CPU while high.
REQ-008 mem_rd  out  1  CPU-bus read request.
REQ-009 mem_addr  out  ADDR_W  read address {page, idx}.
REQ-010 mem_rdata  in  8  read data, valid exactly one clk after mem_rd.
REQ-011 oam_wr  out  1  PPU OAM write strobe.
REQ-012 oam_addr  out  8  OAM byte index.
REQ-013 oam_wdata  out  8  OAM write data.
REQ-014 busy  out  1  high from the cycle after accepted reg_wr until done.
REQ-015 done  out  1  one-cycle pulse at transfer end.

Function
REQ-016 Internal parity bit toggles every clk; it is 0 in the first cycle after reset.
REQ-017 FSM states IDLE, HALT, ALIGN, READ, WRITE.
REQ-018 IDLE: reg_wr=1 latches reg_wdata as page, clears idx, goes to HALT.
REQ-019 HALT lasts one cycle; next state is READ if the next cycle's parity is 0, else ALIGN.
REQ-020 ALIGN lasts one cycle, then READ.
REQ-021 READ: mem_rd=1, mem_addr={page, idx}, next WRITE.
REQ-022 WRITE: oam_wr=1, oam_addr=idx, oam_wdata=mem_rdata; if idx=XFER_LEN-1 then IDLE, else idx+1 and READ.
REQ-023 Total halt is 1+2*XFER_LEN cycles when aligned, 2+2*XFER_LEN otherwise (513/514 at default).
REQ-024 cpu_halt and busy are high in HALT, ALIGN, READ, WRITE and low in IDLE.
REQ-025 done pulses in the first IDLE cycle after the final WRITE.
REQ-026 mem_rd and oam_wr are never high in the same cycle.
REQ-027 reg_wr while busy is ignored; page and idx are unchanged.
REQ-028 mem_addr and oam_addr are 0 whenever mem_rd or oam_wr, respectively, is low.
REQ-029 idx never exceeds XFER_LEN-1; there is no wrap into the next page.

Reset
REQ-030 rst forces IDLE, parity=0, page=0, idx=0, and all outputs to 0 on the next clk edge.
REQ-031 rst mid-transfer aborts with no done pulse; rst wins over a simultaneous reg_wr.

Configuration
REQ-032 Macro OAM_DMA_ABORT_EN adds input dma_abort (1 bit).
REQ-033 With the macro defined, dma_abort=1 in READ or WRITE sets a sticky flag; after the current WRITE the FSM goes to IDLE and done pulses normally.
REQ-034 Without the macro, the port is absent and transfers always run to XFER_LEN.

Structure
REQ-035 Package nes_pkg holds the state enum, DMA_REG_ADDR=16'h4014 and OAM_SIZE=256.
REQ-036 The parity toggle and FSM are implemented inline; no sub-module is needed.

Verification
REQ-037 After reset, reg_wr with 0x02 at parity 0 -> cpu_halt high exactly 513 cycles; 256 oam_wr pulses; mem_addr runs 0x0200..0x02FF; one done pulse.
REQ-038 Same write at parity 1 -> cpu_halt high exactly 514 cycles, with one ALIGN cycle before the first READ.
REQ-039 Memory model returns addr[7:0]^0xA5 -> OAM[k]==k^0xA5 for all k in 0..255.
REQ-040 Second reg_wr with 0x07 mid-transfer -> ignored; all addresses keep page 0x02; write count is still 256.
REQ-041 rst asserted during the 100th WRITE -> next cycle all outputs are 0 with no done; a later reg_wr with 0x03 restarts at mem_addr 0x0300.
REQ-042 OAM_DMA_ABORT_EN: dma_abort during the 11th READ -> exactly 11 oam_wr pulses, then done, and cpu_halt drops.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared constants and FSM state encodings for the NES OAM DMA engine.
package nes_pkg;

  localparam logic [15:0]  DMA_REG_ADDR = 16'h4014;
  localparam int unsigned  OAM_SIZE     = 256;
  localparam int unsigned  STATE_W      = 3;

  typedef logic [STATE_W-1:0] dma_state_t;

  localparam dma_state_t ST_IDLE  = 3'd0;
  localparam dma_state_t ST_HALT  = 3'd1;
  localparam dma_state_t ST_ALIGN = 3'd2;
  localparam dma_state_t ST_READ  = 3'd3;
  localparam dma_state_t ST_WRITE = 3'd4;

endpackage

// File: rtl/oam_dma_if.sv
// CPU register, CPU-bus read and PPU OAM write signals of the OAM DMA engine.
// OAM_DMA_ABORT_EN adds the dma_abort request line.
interface oam_dma_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              reg_wr;
  logic [7:0]        reg_wdata;
  logic              cpu_halt;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              oam_wr;
  logic [7:0]        oam_addr;
  logic [7:0]        oam_wdata;
  logic              busy;
  logic              done;
`ifdef OAM_DMA_ABORT_EN
  logic              dma_abort;

  modport slave (
    input  reg_wr, reg_wdata, mem_rdata, dma_abort,
    output cpu_halt, mem_rd, mem_addr, oam_wr, oam_addr, oam_wdata, busy, done
  );

  modport master (
    output reg_wr, reg_wdata, mem_rdata, dma_abort,
    input  cpu_halt, mem_rd, mem_addr, oam_wr, oam_addr, oam_wdata, busy, done
  );
`else
  modport slave (
    input  reg_wr, reg_wdata, mem_rdata,
    output cpu_halt, mem_rd, mem_addr, oam_wr, oam_addr, oam_wdata, busy, done
  );

  modport master (
    output reg_wr, reg_wdata, mem_rdata,
    input  cpu_halt, mem_rd, mem_addr, oam_wr, oam_addr, oam_wdata, busy, done
  );
`endif
endinterface

// File: rtl/oam_dma.sv
// NES sprite DMA: halts the CPU and copies one page of CPU memory into PPU OAM.
// Optional OAM_DMA_ABORT_EN ends a transfer early after the current byte.
module oam_dma
  import nes_pkg::*;
#(
  parameter int unsigned XFER_LEN = 256,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic     clk,
  input  logic     rst,
  oam_dma_if.slave bus
);

  localparam int unsigned IDX_W    = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

  if (XFER_LEN < 2 || XFER_LEN > OAM_SIZE || (XFER_LEN & (XFER_LEN - 1)) != 0) begin : g_bad_len
    $error("oam_dma: XFER_LEN must be a power of two in 2..256");
  end

  dma_state_t        state_q, state_d;
  logic              parity_q;
  logic [7:0]        page_q, page_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              halt_q, halt_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              oam_wr_q, oam_wr_d;
  logic [7:0]        oam_addr_q, oam_addr_d;
  logic              done_q, done_d;
  logic              stop_c;

`ifdef OAM_DMA_ABORT_EN
  logic abort_q, abort_d;
  assign stop_c = abort_q | bus.dma_abort;
`else
  assign stop_c = 1'b0;
`endif

  // Next state; outputs are registered from the next state so they track the state register.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
`ifdef OAM_DMA_ABORT_EN
    abort_d  = abort_q;
    if (state_q == ST_IDLE) begin
      abort_d = 1'b0;
    end else if (bus.dma_abort && (state_q == ST_READ || state_q == ST_WRITE)) begin
      abort_d = 1'b1;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.reg_wr) begin
          page_d  = bus.reg_wdata;
          idx_d   = '0;
          state_d = ST_HALT;
        end
      end
      // Reads must land on an even-parity cycle; parity flips each clock.
      ST_HALT:  state_d = parity_q ? ST_READ : ST_ALIGN;
      ST_ALIGN: state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (idx_q == LAST_IDX || stop_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    halt_d     = (state_d != ST_IDLE);
    mem_rd_d   = (state_d == ST_READ);
    oam_wr_d   = (state_d == ST_WRITE);
    mem_addr_d = mem_rd_d ? ADDR_W'({page_d, idx_d}) : '0;
    oam_addr_d = oam_wr_d ? idx_d : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      parity_q   <= 1'b0;
      page_q     <= 8'h00;
      idx_q      <= '0;
      halt_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      oam_wr_q   <= 1'b0;
      oam_addr_q <= 8'h00;
      done_q     <= 1'b0;
`ifdef OAM_DMA_ABORT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      parity_q   <= ~parity_q;
      page_q     <= page_d;
      idx_q      <= idx_d;
      halt_q     <= halt_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      oam_wr_q   <= oam_wr_d;
      oam_addr_q <= oam_addr_d;
      done_q     <= done_d;
`ifdef OAM_DMA_ABORT_EN
      abort_q    <= abort_d;
`endif
    end
  end

  assign bus.cpu_halt  = halt_q;
  assign bus.busy      = halt_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.oam_wr    = oam_wr_q;
  assign bus.oam_addr  = oam_addr_q;
  // Read data arrives during WRITE, so it is forwarded straight to OAM.
  assign bus.oam_wdata = oam_wr_q ? bus.mem_rdata : 8'h00;
  assign bus.done      = done_q;

endmodule
